// File: rtl/ozphy_ts_gen.sv
// Per-lane TS1/TS2 ordered-set generator feeding the 8b/10b encoder.
// Emits NTS back-to-back 16-symbol sets per start; all outputs registered.
module ozphy_ts_gen #(
    parameter int          NTS     = 1024,
    parameter logic [7:0]  RATE_ID = 8'h02
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        abort,
    input  logic        ts_type,
    input  logic        link_pad,
    input  logic        lane_pad,
    input  logic [7:0]  link_num,
    input  logic [4:0]  lane_num,
    input  logic [7:0]  n_fts,
    output logic [7:0]  txdata,
    output logic        txdatak,
    output logic        tx_valid,
    output logic        busy,
    output logic        done,
    output logic [10:0] os_count
);

    typedef enum logic {IDLE, SEND} state_t;

    typedef struct packed {
        logic       ts_type;
        logic       link_pad;
        logic       lane_pad;
        logic [7:0] link_num;
        logic [4:0] lane_num;
        logic [7:0] n_fts;
    } ts_fields_t;

    localparam logic [10:0] LAST_OS = 11'(NTS);

    // Returns {K, data} for one symbol position of an ordered set.
    function automatic logic [8:0] ts_symbol(input logic [3:0] idx, input ts_fields_t f);
        logic [8:0] s;
        case (idx)
            4'd0:    s = {1'b1, 8'hBC};
            4'd1:    s = f.link_pad ? {1'b1, 8'hF7} : {1'b0, f.link_num};
            4'd2:    s = f.lane_pad ? {1'b1, 8'hF7} : {1'b0, 3'b000, f.lane_num};
            4'd3:    s = {1'b0, f.n_fts};
            4'd4:    s = {1'b0, RATE_ID};
            4'd5:    s = 9'h000;
            default: s = f.ts_type ? {1'b0, 8'h45} : {1'b0, 8'h4A};
        endcase
        return s;
    endfunction

    state_t      state, state_n;
    ts_fields_t  fld, fld_n, fld_in;
    logic [3:0]  sym_idx, idx_n;
    logic [10:0] cnt_n;
    logic [8:0]  sym_n;
    logic        valid_n, done_n;

    assign fld_in = '{ts_type, link_pad, lane_pad, link_num, lane_num, n_fts};
    assign busy   = (state == SEND);

    always_comb begin
        state_n = state;
        fld_n   = fld;
        idx_n   = sym_idx;
        cnt_n   = os_count;
        sym_n   = 9'h000;
        valid_n = 1'b0;
        done_n  = 1'b0;
        case (state)
            IDLE: begin
                if (start && !abort) begin
                    state_n = SEND;
                    fld_n   = fld_in;
                    idx_n   = 4'd0;
                    cnt_n   = 11'd0;
                    sym_n   = ts_symbol(4'd0, fld_in);
                    valid_n = 1'b1;
                end
            end
            SEND: begin
                if (abort) begin
                    state_n = IDLE;
                end else if (sym_idx == 4'd15 && os_count == LAST_OS) begin
                    state_n = IDLE;
                    done_n  = 1'b1;
                end else begin
                    // os_count already counts the set whose symbol 15 is on the wire
                    idx_n   = sym_idx + 4'd1;
                    sym_n   = ts_symbol(idx_n, fld);
                    valid_n = 1'b1;
                    if (idx_n == 4'd15) cnt_n = os_count + 11'd1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            fld      <= '0;
            sym_idx  <= 4'd0;
            os_count <= 11'd0;
            txdata   <= 8'h00;
            txdatak  <= 1'b0;
            tx_valid <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_n;
            fld      <= fld_n;
            sym_idx  <= idx_n;
            os_count <= cnt_n;
            {txdatak, txdata} <= sym_n;
            tx_valid <= valid_n;
            done     <= done_n;
        end
    end

endmodule
